// File: rtl/multicycle_mainfsm_pkg.sv
// multicycle_mainfsm_pkg: state encodings and control-field constants shared by the main FSM and its output decoder.
package multicycle_mainfsm_pkg;
    localparam int STATE_W_DEFAULT = 4;
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } mainState_t;
    localparam logic [1:0] SRCA_REG      = 2'b00;
    localparam logic [1:0] SRCA_PC       = 2'b01;
    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
endpackage

// File: rtl/multicycle_mainfsm_outdec.sv
// mainfsm_outdec: Moore decode of the main FSM state into its control word; unknown encodings decode to all zeros.
module mainfsm_outdec
    import multicycle_mainfsm_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEFAULT
) (
    input  logic [STATE_W-1:0] State,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               ALUOp
);
    logic       stateOk;
    mainState_t cur;
    assign stateOk = (State >> 4) == '0;
    assign cur     = mainState_t'(State[3:0]);
    always_comb begin
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = SRCA_REG;
        ALUSrcB   = SRCB_REG;
        ResultSrc = RES_ALUOUT;
        NextPC    = 1'b0;
        RegW      = 1'b0;
        MemW      = 1'b0;
        Branch    = 1'b0;
        ALUOp     = 1'b0;
        if (stateOk)
            case (cur)
                FETCH: begin
                    IRWrite   = 1'b1;
                    NextPC    = 1'b1;
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                DECODE: begin
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURESULT;
                end
                MEMADR:   ALUSrcB = SRCB_IMM;
                MEMREAD:  AdrSrc = 1'b1;
                MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegW      = 1'b1;
                end
                MEMWRITE: begin
                    AdrSrc = 1'b1;
                    MemW   = 1'b1;
                end
                EXECUTER: ALUOp = 1'b1;
                EXECUTEI: begin
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = 1'b1;
                end
                ALUWB:    RegW = 1'b1;
                BRANCH: begin
                    ALUSrcB   = SRCB_IMM;
                    ResultSrc = RES_ALURESULT;
                    Branch    = 1'b1;
                end
                default: ;
            endcase
    end
endmodule

// File: rtl/multicycle_mainfsm.sv
// multicycle_mainfsm: main control FSM of the multicycle ARM core (state register + next-state logic).
// Define MAINFSM_MEMREADY_EN to add a MemReady handshake that stalls FETCH, MEMREAD and MEMWRITE.
module multicycle_mainfsm
    import multicycle_mainfsm_pkg::*;
#(
    parameter int STATE_W = STATE_W_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
`ifdef MAINFSM_MEMREADY_EN
    input  logic               MemReady,
`endif
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    output logic               IRWrite,
    output logic               AdrSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ResultSrc,
    output logic               NextPC,
    output logic               RegW,
    output logic               MemW,
    output logic               Branch,
    output logic               ALUOp,
    output logic [STATE_W-1:0] State
);
    logic [STATE_W-1:0] state;
    logic               stateOk, memReady, irWriteDec, nextPcDec, unusedFunct;
    mainState_t         cur, nxt;
`ifdef MAINFSM_MEMREADY_EN
    assign memReady = MemReady;
`else
    assign memReady = 1'b1;
`endif
    assign unusedFunct = ^Funct[4:1];
    assign stateOk     = (state >> 4) == '0;
    assign cur         = mainState_t'(state[3:0]);
    always_comb begin
        nxt = FETCH;
        if (stateOk)
            case (cur)
                FETCH:    nxt = memReady ? DECODE : FETCH;
                DECODE:   nxt = (Op == 2'b00) ? (Funct[5] ? EXECUTEI : EXECUTER) :
                                (Op == 2'b01) ? MEMADR :
                                (Op == 2'b10) ? BRANCH : FETCH;
                MEMADR:   nxt = Funct[0] ? MEMREAD : MEMWRITE;
                MEMREAD:  nxt = memReady ? MEMWB : MEMREAD;
                MEMWRITE: nxt = memReady ? FETCH : MEMWRITE;
                EXECUTER: nxt = ALUWB;
                EXECUTEI: nxt = ALUWB;
                default:  nxt = FETCH;
            endcase
    end
    always_ff @(posedge clk or negedge reset)
        if (!reset) state <= '0;
        else        state <= STATE_W'(nxt);
    mainfsm_outdec #(.STATE_W(STATE_W)) uOutdec (
        .State(state),
        .IRWrite(irWriteDec),
        .AdrSrc(AdrSrc),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc),
        .NextPC(nextPcDec),
        .RegW(RegW),
        .MemW(MemW),
        .Branch(Branch),
        .ALUOp(ALUOp)
    );
    // IR load and PC increment only when the fetch actually completes
    assign IRWrite = irWriteDec & memReady;
    assign NextPC  = nextPcDec & memReady;
    assign State   = state;
endmodule

// File: doc/multicycle_mainfsm.md
Name: multicycle_mainfsm

Overview:
Main control state machine of the multicycle ARM core wrapped by top. It sits directly upstream of the datapath and memory: it sequences fetch, decode, memory, ALU and branch steps, and drives the enables and mux selects that produce Adr, WriteData and MemWrite at top level. It receives Op/Funct from the instruction register. Condition-code gating of RegW/MemW and the ALU decoder live outside this block.

Parameters:
STATE_W, 4, width of the state register and of the debug State output; must be >= 4.

Ports:
clk  input  1  system clock, rising-edge active
reset  input  1  asynchronous, active-low reset; 0 = in reset
Op  input  2  instruction bits [27:26]
Funct  input  6  instruction bits [25:20]; Funct[5] = I bit, Funct[0] = L bit for memory ops
IRWrite  output  1  instruction register load enable
AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result
ALUSrcA  output  2  ALU A select: 0 = register A, 1 = PC
ALUSrcB  output  2  ALU B select: 00 = register, 01 = extended immediate, 10 = constant 4
ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
NextPC  output  1  PC update request
RegW  output  1  register write request (ungated)
MemW  output  1  memory write request (ungated)
Branch  output  1  branch request
ALUOp  output  1  1 = ALU decoder uses Funct; 0 = add
State  output  STATE_W  current state, for debug and the bench

Behaviour:
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9.
- The state register updates on the rising clk edge.
- reset=0 forces FETCH immediately (asynchronous). Release takes effect at the first rising edge with reset=1. Reset mid-instruction aborts the instruction with no further RegW/MemW.
- Transitions:
  - FETCH->DECODE.
  - DECODE: Op=00 & Funct[5]=0 -> EXECUTER; Op=00 & Funct[5]=1 -> EXECUTEI; Op=01 -> MEMADR; Op=10 -> BRANCH; Op=11 -> FETCH (undefined op, no side effects).
  - MEMADR: Funct[0]=1 -> MEMREAD, else MEMWRITE.
  - MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH; EXECUTER/EXECUTEI->ALUWB->FETCH; BRANCH->FETCH.
  - Encodings 10..2^STATE_W-1 -> FETCH.
- Outputs are Moore (decoded from State only). Every output not listed for a state is 0.
  - FETCH: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcB=01.
  - MEMREAD: AdrSrc=1.
  - MEMWB: ResultSrc=01, RegW=1.
  - MEMWRITE: AdrSrc=1, MemW=1.
  - EXECUTER: ALUOp=1.
  - EXECUTEI: ALUSrcB=01, ALUOp=1.
  - ALUWB: RegW=1.
  - BRANCH: ALUSrcB=01, ResultSrc=10, Branch=1.
- Reset values = FETCH decode: IRWrite=1, NextPC=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, all others 0, State=0. PC/IR are held in reset by the same signal.
- Latency in cycles: load 5, store 4, data-processing 4, branch 3, undefined op 2.

Optional Feature:
MAINFSM_MEMREADY_EN
- With the macro: adds input MemReady (1 bit).
  - FETCH, MEMREAD and MEMWRITE hold until MemReady=1.
  - In FETCH, IRWrite and NextPC are asserted only when MemReady=1 (Mealy gating), giving exactly one PC increment per fetch.
  - MemW stays 1 throughout a stalled MEMWRITE.
- Without the macro: no MemReady port; behaviour is identical to MemReady tied to 1.

Decomposition:
- Shared package: state localparams, ALUSrcA/ALUSrcB/ResultSrc encoding constants, STATE_W default.
- One sub-module: mainfsm_outdec, a purely combinational State->control-word decoder, instantiated once.
- Next-state logic and the state register stay in multicycle_mainfsm.

Test Plan:
- Reset hold: reset=0 for 3 cycles with arbitrary Op -> State=0, IRWrite=1, NextPC=1, RegW=0, MemW=0. Assert reset=0 mid-MEMWRITE -> State=0 within the same cycle, MemW=0.
- LDR: Op=01, Funct=011001 -> State sequence 0,1,2,3,4,0. AdrSrc=1 in state 3. RegW=1 only in state 4 with ResultSrc=01.
- STR: Op=01, Funct=011000 -> sequence 0,1,2,5,0. MemW=1 for exactly one cycle with AdrSrc=1.
- Data-processing: ADD reg (Op=00, Funct=001000) -> 0,1,6,8,0 with ALUOp=1, ALUSrcB=00 in state 6. ADD imm (Funct=101000) -> 0,1,7,8,0 with ALUSrcB=01.
- Branch and undefined: Op=10 -> 0,1,9,0 with Branch=1, ResultSrc=10 in state 9. Op=11 -> 0,1,0 with RegW, MemW and Branch never 1.
- With MAINFSM_MEMREADY_EN: MemReady=0 for 3 cycles in FETCH -> State stays 0, NextPC=0. On MemReady=1 -> NextPC=1 for one cycle, then DECODE.
